// File: rtl/skew_loader.sv
// skew_loader: reads NUM_ROW source vectors and writes them diagonally skewed into the
// left or top SRAM bank, so lane j lags lane 0 by j cycles, then publishes the read window.
module skew_loader #(
  parameter int NUM_ROW              = 8,
  parameter int NUM_COL              = 8,
  parameter int DATA_WIDTH           = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int BUF_ID_WIDTH         = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_req_valid,
  output logic                               o_req_ready,
  input  logic [BUF_ID_WIDTH-1:0]            i_buf_id,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]    i_mem_loc,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]    i_src_addr,
  output logic                               o_src_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_src_rd_addr,
  input  logic [NUM_ROW*DATA_WIDTH-1:0]      i_src_rd_data,
  output logic                               o_left_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_left_wr_addr,
  output logic [NUM_ROW*DATA_WIDTH-1:0]      o_left_wr_data,
  output logic                               o_top_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_top_wr_addr,
  output logic [NUM_COL*DATA_WIDTH-1:0]      o_top_wr_data,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]    o_top_sram_rd_end_addr,
  output logic                               o_done,
  output logic                               o_err
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int DW = DATA_WIDTH;
  localparam int VW = NUM_ROW * DATA_WIDTH;
  localparam int CW = $clog2(2 * NUM_ROW + 3);

  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_N        = CW'(NUM_ROW);
  localparam logic [CW-1:0] CNT_WR_FIRST = CW'(2);
  localparam logic [CW-1:0] CNT_WR_LAST  = CW'(2 * NUM_ROW);
  localparam logic [CW-1:0] CNT_END      = CW'(2 * NUM_ROW + 1);
  localparam logic [AW-1:0] WIN_SPAN     = AW'(2 * NUM_ROW - 1);

  localparam logic [BUF_ID_WIDTH-1:0] BUF_LEFT = BUF_ID_WIDTH'(0);
  localparam logic [BUF_ID_WIDTH-1:0] BUF_TOP  = BUF_ID_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BUF_ID_WIDTH-1:0] buf_q, buf_d;
  logic [AW-1:0]           mem_q, mem_d;
  logic [AW-1:0]           base_q, base_d;
  logic                    rd_en_q, rd_en_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic                    src_valid_q, src_valid_d;
  logic                    left_wr_en_q, left_wr_en_d;
  logic [AW-1:0]           left_wr_addr_q, left_wr_addr_d;
  logic [VW-1:0]           left_wr_data_q, left_wr_data_d;
  logic                    top_wr_en_q, top_wr_en_d;
  logic [AW-1:0]           top_wr_addr_q, top_wr_addr_d;
  logic [VW-1:0]           top_wr_data_q, top_wr_data_d;
  logic [AW-1:0]           left_start_q, left_start_d;
  logic [AW-1:0]           left_end_q, left_end_d;
  logic [AW-1:0]           top_start_q, top_start_d;
  logic [AW-1:0]           top_end_q, top_end_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    wr_go;
  logic [AW-1:0]           wr_addr;
  logic [VW-1:0]           lane_tap;

  // Source data is only trusted the cycle after a read; otherwise zeros flush the chains.
  for (genvar j = 0; j < NUM_ROW; j++) begin : g_lane
    logic [DW-1:0] lane_in;
    assign lane_in = src_valid_q ? i_src_rd_data[j*DW +: DW] : '0;

    if (j == 0) begin : g_direct
      assign lane_tap[DW-1:0] = lane_in;
    end else begin : g_chain
      logic [DW-1:0] chain_q [j];
      logic [DW-1:0] chain_d [j];

      always_comb begin
        chain_d[0] = lane_in;
        for (int k = 1; k < j; k++) chain_d[k] = chain_q[k-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < j; k++) chain_q[k] <= '0;
        end else begin
          chain_q <= chain_d;
        end
      end

      assign lane_tap[j*DW +: DW] = chain_q[j-1];
    end
  end

  // Write t lands on cycle t+3, so the write registers load while cnt_q is 2..2N.
  always_comb begin
    wr_go   = (state_q == READ || state_q == FLUSH) &&
              (cnt_q >= CNT_WR_FIRST) && (cnt_q <= CNT_WR_LAST);
    wr_addr = mem_q + AW'(cnt_q - CNT_WR_FIRST);
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    buf_d          = buf_q;
    mem_d          = mem_q;
    base_d         = base_q;
    rd_en_d        = 1'b0;
    rd_addr_d      = '0;
    src_valid_d    = rd_en_q;
    left_start_d   = left_start_q;
    left_end_d     = left_end_q;
    top_start_d    = top_start_q;
    top_end_d      = top_end_q;
    done_d         = 1'b0;
    err_d          = 1'b0;

    left_wr_en_d   = wr_go && (buf_q == BUF_LEFT);
    left_wr_addr_d = left_wr_en_d ? wr_addr : '0;
    left_wr_data_d = left_wr_en_d ? lane_tap : '0;
    top_wr_en_d    = wr_go && (buf_q == BUF_TOP);
    top_wr_addr_d  = top_wr_en_d ? wr_addr : '0;
    top_wr_data_d  = top_wr_en_d ? lane_tap : '0;

    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          buf_d  = i_buf_id;
          mem_d  = i_mem_loc;
          base_d = i_src_addr;
          cnt_d  = CNT_ONE;
          if (i_buf_id == BUF_LEFT || i_buf_id == BUF_TOP) begin
            state_d   = READ;
            rd_en_d   = 1'b1;
            rd_addr_d = i_src_addr;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
          end
        end
      end
      READ: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q < CNT_N) begin
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + AW'(cnt_q);
        end else begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_END) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (buf_q == BUF_LEFT) begin
            left_start_d = mem_q;
            left_end_d   = mem_q + WIN_SPAN;
          end else begin
            top_start_d = mem_q;
            top_end_d   = mem_q + WIN_SPAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      buf_q          <= '0;
      mem_q          <= '0;
      base_q         <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      src_valid_q    <= 1'b0;
      left_wr_en_q   <= 1'b0;
      left_wr_addr_q <= '0;
      left_wr_data_q <= '0;
      top_wr_en_q    <= 1'b0;
      top_wr_addr_q  <= '0;
      top_wr_data_q  <= '0;
      left_start_q   <= '0;
      left_end_q     <= '0;
      top_start_q    <= '0;
      top_end_q      <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      buf_q          <= buf_d;
      mem_q          <= mem_d;
      base_q         <= base_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      src_valid_q    <= src_valid_d;
      left_wr_en_q   <= left_wr_en_d;
      left_wr_addr_q <= left_wr_addr_d;
      left_wr_data_q <= left_wr_data_d;
      top_wr_en_q    <= top_wr_en_d;
      top_wr_addr_q  <= top_wr_addr_d;
      top_wr_data_q  <= top_wr_data_d;
      left_start_q   <= left_start_d;
      left_end_q     <= left_end_d;
      top_start_q    <= top_start_d;
      top_end_q      <= top_end_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign o_req_ready               = (state_q == IDLE);
  assign o_src_rd_en               = rd_en_q;
  assign o_src_rd_addr             = rd_addr_q;
  assign o_left_wr_en              = left_wr_en_q;
  assign o_left_wr_addr            = left_wr_addr_q;
  assign o_left_wr_data            = left_wr_data_q;
  assign o_top_wr_en               = top_wr_en_q;
  assign o_top_wr_addr             = top_wr_addr_q;
  assign o_top_wr_data             = top_wr_data_q;
  assign o_left_sram_rd_start_addr = left_start_q;
  assign o_left_sram_rd_end_addr   = left_end_q;
  assign o_top_sram_rd_start_addr  = top_start_q;
  assign o_top_sram_rd_end_addr    = top_end_q;
  assign o_done                    = done_q;
  assign o_err                     = err_q;

endmodule

// File: tb/tb_skew_loader.sv
// tb_skew_loader: scenario tasks drive skew_loader against a source-memory model and a
// cycle-indexed reference derived from the write schedule (write t on cycle t+3).
module tb_skew_loader;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int VW = N * DW;
  localparam int OW = 2 + 2 * AW + 2 * (1 + AW + VW) + 4 * AW + 1;

  logic          clk;
  logic          rst_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [1:0]    i_buf_id;
  logic [AW-1:0] i_mem_loc;
  logic [AW-1:0] i_src_addr;
  logic          o_src_rd_en;
  logic [AW-1:0] o_src_rd_addr;
  logic [VW-1:0] i_src_rd_data;
  logic          o_left_wr_en;
  logic [AW-1:0] o_left_wr_addr;
  logic [VW-1:0] o_left_wr_data;
  logic          o_top_wr_en;
  logic [AW-1:0] o_top_wr_addr;
  logic [VW-1:0] o_top_wr_data;
  logic [AW-1:0] o_left_sram_rd_start_addr;
  logic [AW-1:0] o_left_sram_rd_end_addr;
  logic [AW-1:0] o_top_sram_rd_start_addr;
  logic [AW-1:0] o_top_sram_rd_end_addr;
  logic          o_done;
  logic          o_err;

  logic [VW-1:0] src_mem [1024];
  logic [AW-1:0] cap_addr [2*N-1];
  logic [VW-1:0] cap_data [2*N-1];
  logic [AW-1:0] exp_ls, exp_le, exp_ts, exp_te;
  int            n_tests;
  int            n_fail;
  logic [OW-1:0] out_bus;

  skew_loader dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .i_req_valid               (i_req_valid),
    .o_req_ready               (o_req_ready),
    .i_buf_id                  (i_buf_id),
    .i_mem_loc                 (i_mem_loc),
    .i_src_addr                (i_src_addr),
    .o_src_rd_en               (o_src_rd_en),
    .o_src_rd_addr             (o_src_rd_addr),
    .i_src_rd_data             (i_src_rd_data),
    .o_left_wr_en              (o_left_wr_en),
    .o_left_wr_addr            (o_left_wr_addr),
    .o_left_wr_data            (o_left_wr_data),
    .o_top_wr_en               (o_top_wr_en),
    .o_top_wr_addr             (o_top_wr_addr),
    .o_top_wr_data             (o_top_wr_data),
    .o_left_sram_rd_start_addr (o_left_sram_rd_start_addr),
    .o_left_sram_rd_end_addr   (o_left_sram_rd_end_addr),
    .o_top_sram_rd_start_addr  (o_top_sram_rd_start_addr),
    .o_top_sram_rd_end_addr    (o_top_sram_rd_end_addr),
    .o_done                    (o_done),
    .o_err                     (o_err)
  );

  assign out_bus = {o_src_rd_en, o_src_rd_addr,
                    o_left_wr_en, o_left_wr_addr, o_left_wr_data,
                    o_top_wr_en, o_top_wr_addr, o_top_wr_data,
                    o_left_sram_rd_start_addr, o_left_sram_rd_end_addr,
                    o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
                    o_done, o_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source SRAM: one-cycle read latency; junk on the bus when not reading.
  always @(posedge clk) begin
    if (o_src_rd_en === 1'b1) i_src_rd_data <= src_mem[o_src_rd_addr];
    else                      i_src_rd_data <= {$urandom, $urandom};
  end

  // Runs one request from an IDLE negedge and checks every cycle until ready returns.
  task automatic run_load(input logic [1:0] bid, input logic [AW-1:0] s,
                          input logic [AW-1:0] b, input bit hold);
    bit                vid;
    int                last_c;
    int                rd_count;
    int                t;
    logic              exp_rd_en;
    logic [AW-1:0]     exp_rd_addr;
    logic              wr_act;
    logic [AW-1:0]     exp_wa;
    logic [VW-1:0]     exp_wd;
    logic [AW-1:0]     a;
    logic [AW+VW:0]    exp_left, exp_top;
    logic [2:0]        exp_ctl;
    logic [4*AW-1:0]   exp_win;
    vid      = (bid == 2'd0) || (bid == 2'd1);
    last_c   = vid ? 2 * N + 3 : 3;
    rd_count = 0;
    n_tests++;
    if (o_req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_before_load: got %b expected 1", o_req_ready);
    end
    i_req_valid = 1'b1;
    i_buf_id    = bid;
    i_mem_loc   = s;
    i_src_addr  = b;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (!hold || c == last_c) i_req_valid = 1'b0;
      i_buf_id   = 2'($urandom);
      i_mem_loc  = AW'($urandom);
      i_src_addr = AW'($urandom);

      exp_rd_en   = vid && (c <= N);
      exp_rd_addr = exp_rd_en ? b + AW'(c - 1) : '0;
      if (o_src_rd_en === 1'b1) rd_count++;
      n_tests++;
      if ({o_src_rd_en, o_src_rd_addr} !== {exp_rd_en, exp_rd_addr}) begin
        n_fail++;
        $display("[TB] FAIL src_read c=%0d: got en=%b addr=%h expected en=%b addr=%h",
                 c, o_src_rd_en, o_src_rd_addr, exp_rd_en, exp_rd_addr);
      end

      t      = c - 3;
      wr_act = vid && (t >= 0) && (t <= 2 * N - 2);
      exp_wa = wr_act ? s + AW'(t) : '0;
      exp_wd = '0;
      if (wr_act) begin
        for (int j = 0; j < N; j++) begin
          if (t - j >= 0 && t - j < N) begin
            a = b + AW'(t - j);
            exp_wd[j*DW +: DW] = src_mem[a][j*DW +: DW];
          end
        end
      end
      exp_left = (wr_act && bid == 2'd0) ? {1'b1, exp_wa, exp_wd} : '0;
      exp_top  = (wr_act && bid == 2'd1) ? {1'b1, exp_wa, exp_wd} : '0;
      n_tests++;
      if ({o_left_wr_en, o_left_wr_addr, o_left_wr_data} !== exp_left) begin
        n_fail++;
        $display("[TB] FAIL left_write c=%0d: got %h expected %h", c,
                 {o_left_wr_en, o_left_wr_addr, o_left_wr_data}, exp_left);
      end
      n_tests++;
      if ({o_top_wr_en, o_top_wr_addr, o_top_wr_data} !== exp_top) begin
        n_fail++;
        $display("[TB] FAIL top_write c=%0d: got %h expected %h", c,
                 {o_top_wr_en, o_top_wr_addr, o_top_wr_data}, exp_top);
      end
      if (wr_act) begin
        cap_addr[t] = (bid == 2'd0) ? o_left_wr_addr : o_top_wr_addr;
        cap_data[t] = (bid == 2'd0) ? o_left_wr_data : o_top_wr_data;
      end

      exp_ctl = {vid && (c == 2 * N + 2), !vid && (c == 1),
                 vid ? (c == 2 * N + 3) : (c >= 2)};
      n_tests++;
      if ({o_done, o_err, o_req_ready} !== exp_ctl) begin
        n_fail++;
        $display("[TB] FAIL done_err_ready c=%0d: got %b expected %b", c,
                 {o_done, o_err, o_req_ready}, exp_ctl);
      end

      if (vid && c == 2 * N + 2) begin
        if (bid == 2'd0) begin
          exp_ls = s;
          exp_le = s + AW'(2 * N - 1);
        end else begin
          exp_ts = s;
          exp_te = s + AW'(2 * N - 1);
        end
      end
      exp_win = {exp_ls, exp_le, exp_ts, exp_te};
      n_tests++;
      if ({o_left_sram_rd_start_addr, o_left_sram_rd_end_addr,
           o_top_sram_rd_start_addr, o_top_sram_rd_end_addr} !== exp_win) begin
        n_fail++;
        $display("[TB] FAIL rd_windows c=%0d: got %h expected %h", c,
                 {o_left_sram_rd_start_addr, o_left_sram_rd_end_addr,
                  o_top_sram_rd_start_addr, o_top_sram_rd_end_addr}, exp_win);
      end
    end
    n_tests++;
    if (rd_count != (vid ? N : 0)) begin
      n_fail++;
      $display("[TB] FAIL read_count: got %0d expected %0d", rd_count, vid ? N : 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_bus !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", out_bus);
    end
    n_tests++;
    if (o_req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b expected 1", o_req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({out_bus, o_req_ready} !== {{OW{1'b0}}, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %h expected ready only", {out_bus, o_req_ready});
    end
  endtask

  task automatic test_left_load();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) v[j*DW +: DW] = 8'((k << 4) | j);
      src_mem[k] = v;
    end
    run_load(2'd0, 10'h010, 10'h000, 1'b0);
    n_tests++;
    if ({cap_addr[0], cap_data[0]} !== {10'h010, 64'h0}) begin
      n_fail++;
      $display("[TB] FAIL left_first_write: got %h/%h expected 010/0", cap_addr[0], cap_data[0]);
    end
    n_tests++;
    if ({cap_addr[7], cap_data[7]} !== {10'h017, 64'h0716253443526170}) begin
      n_fail++;
      $display("[TB] FAIL left_mid_write: got %h/%h expected 017/0716253443526170",
               cap_addr[7], cap_data[7]);
    end
    n_tests++;
    if ({cap_addr[14], cap_data[14]} !== {10'h01E, 64'h7700000000000000}) begin
      n_fail++;
      $display("[TB] FAIL left_last_write: got %h/%h expected 01e/7700000000000000",
               cap_addr[14], cap_data[14]);
    end
    n_tests++;
    if ({o_left_sram_rd_start_addr, o_left_sram_rd_end_addr} !== {10'h010, 10'h01F}) begin
      n_fail++;
      $display("[TB] FAIL left_window: got %h/%h expected 010/01f",
               o_left_sram_rd_start_addr, o_left_sram_rd_end_addr);
    end
  endtask

  task automatic test_top_load();
    run_load(2'd1, 10'h120, 10'h000, 1'b0);
    n_tests++;
    if ({cap_addr[7], cap_data[7]} !== {10'h127, 64'h0716253443526170}) begin
      n_fail++;
      $display("[TB] FAIL top_mid_write: got %h/%h expected 127/0716253443526170",
               cap_addr[7], cap_data[7]);
    end
    n_tests++;
    if ({o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
         o_left_sram_rd_start_addr, o_left_sram_rd_end_addr} !==
        {10'h120, 10'h12F, 10'h010, 10'h01F}) begin
      n_fail++;
      $display("[TB] FAIL top_window: got top %h/%h left %h/%h expected 120/12f 010/01f",
               o_top_sram_rd_start_addr, o_top_sram_rd_end_addr,
               o_left_sram_rd_start_addr, o_left_sram_rd_end_addr);
    end
  endtask

  task automatic test_wrap();
    run_load(2'd0, 10'h3F8, AW'($urandom), 1'b0);
    n_tests++;
    if ({cap_addr[7], cap_addr[8], cap_addr[14]} !== {10'h3FF, 10'h000, 10'h006}) begin
      n_fail++;
      $display("[TB] FAIL wrap_addrs: got %h %h %h expected 3ff 000 006",
               cap_addr[7], cap_addr[8], cap_addr[14]);
    end
    n_tests++;
    if ({o_left_sram_rd_start_addr, o_left_sram_rd_end_addr} !== {10'h3F8, 10'h007}) begin
      n_fail++;
      $display("[TB] FAIL wrap_window: got %h/%h expected 3f8/007",
               o_left_sram_rd_start_addr, o_left_sram_rd_end_addr);
    end
  endtask

  task automatic test_invalid();
    run_load(2'd2, AW'($urandom), AW'($urandom), 1'b0);
    run_load(2'd3, AW'($urandom), AW'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid_load();
    i_req_valid = 1'b1;
    i_buf_id    = 2'd0;
    i_mem_loc   = 10'h200;
    i_src_addr  = AW'($urandom);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_bus, o_req_ready} !== {{OW{1'b0}}, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL async_abort: got %h expected ready only", {out_bus, o_req_ready});
    end
    exp_ls = '0;
    exp_le = '0;
    exp_ts = '0;
    exp_te = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * N + 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({out_bus, o_req_ready} !== {{OW{1'b0}}, 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL aborted_stays_idle c=%0d: got %h expected ready only",
                 c, {out_bus, o_req_ready});
      end
    end
    run_load(2'd0, 10'h200, AW'($urandom), 1'b0);
  endtask

  task automatic test_hold_valid();
    run_load(2'd0, AW'($urandom), AW'($urandom), 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({o_src_rd_en, o_req_ready} !== 2'b01) begin
        n_fail++;
        $display("[TB] FAIL single_load_per_accept c=%0d: got en=%b ready=%b expected 0/1",
                 c, o_src_rd_en, o_req_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] bid;
    for (int i = 0; i < 8; i++) begin
      bid = ($urandom_range(0, 7) < 6) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      run_load(bid, AW'($urandom), AW'($urandom), 1'b0);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    i_req_valid = 1'b0;
    i_buf_id    = '0;
    i_mem_loc   = '0;
    i_src_addr  = '0;
    exp_ls      = '0;
    exp_le      = '0;
    exp_ts      = '0;
    exp_te      = '0;
    for (int a = 0; a < 1024; a++) src_mem[a] = {$urandom, $urandom};
    test_reset();
    test_left_load();
    test_top_load();
    test_wrap();
    test_invalid();
    test_reset_mid_load();
    test_hold_valid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
